// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types and widths for the data-memory responder:
//   XLEN / ADDRW / MASKW  - data, address and byte-enable widths
//   dmem_state_e          - responder FSM states
//   dmem_req_t            - one request as seen on the DMEM port
//   dmem_rsp_t            - one registered response
//   mask_legal()          - byte-enable patterns a single lane-aligned
//                           access can legally produce
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ADDRW = 32;
  localparam int unsigned MASKW = XLEN / 8;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_e;

  typedef struct packed {
    logic             valid;
    logic [ADDRW-1:0] addr;
    logic [MASKW-1:0] mask;
    logic [XLEN-1:0]  wdata;
    logic             we;
  } dmem_req_t;

  typedef struct packed {
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;
  } dmem_rsp_t;

  // Byte, aligned halfword and full word enables are the only shapes a
  // naturally aligned load/store can produce.
  function automatic logic mask_legal(input logic [MASKW-1:0] mask);
    logic legal;
    unique case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// DMEM request/response bundle between the execute stage and the responder.
//   valid/addr/mask/wdata/we : request, driven by the requester (master)
//   ready                    : responder can take a request this cycle
//   rvalid/rdata/err         : one-cycle registered response
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic             valid;
  logic [ADDRW-1:0] addr;
  logic [MASKW-1:0] mask;
  logic [XLEN-1:0]  wdata;
  logic             we;
  logic             ready;
  logic             rvalid;
  logic [XLEN-1:0]  rdata;
  logic             err;

  modport master (
    output valid, addr, mask, wdata, we,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  valid, addr, mask, wdata, we,
    output ready, rvalid, rdata, err
  );

endinterface

// File: rtl/dmem_responder_sram_bank.sv
// -----------------------------------------------------------------------------
// dmem_sram_bank
// DEPTH_WORDS x XLEN storage with per-byte write enables, synchronous write
// and combinational read. Kept as its own module so it can be replaced by a
// technology SRAM macro without touching the responder control.
//   clk     : clock
//   byte_en : per-lane write enable (all zero = no write)
//   idx     : word index for both read and write
//   wdata   : lane-aligned write data
//   rdata   : word at idx (reflects writes from earlier edges)
// -----------------------------------------------------------------------------
module dmem_sram_bank
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned IDXW        = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [MASKW-1:0] byte_en,
  input  logic [IDXW-1:0]  idx,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // NOTE: storage has no reset -- a RAM cannot clear all words in one cycle,
  // and a reset branch here would turn the array into flops.
  always_ff @(posedge clk) begin
    for (int b = 0; b < MASKW; b++) begin
      if (byte_en[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory target for the core's DMEM port. Accepts word-aligned requests,
// performs byte-masked stores into a local bank and returns a one-cycle
// response LATENCY cycles after acceptance.
//
// Parameters:
//   DEPTH_WORDS : words of storage (power of two, >= 2)
//   LATENCY     : cycles from accept to response pulse (1..8)
//   BASE_ADDR   : byte address of word 0 (word aligned)
//
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   dmem   : slave side of dmem_responder_if (request in, ready/response out)
//
// Build option:
//   DMEM_RESP_ERR_EN - when defined, out-of-range requests and illegal byte
//   masks raise err in the response and such stores are suppressed. When
//   undefined, err is always 0 and any mask acts as plain byte enables.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned      DEPTH_WORDS = 4096,
  parameter int unsigned      LATENCY     = 1,
  parameter logic [ADDRW-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             clk_i,
  input logic             rst_ni,
  dmem_responder_if.slave dmem
);

  localparam int unsigned      IDXW        = $clog2(DEPTH_WORDS);
  localparam int unsigned      CNTW        = 3;
  // Counter is loaded with LATENCY-2 so that WAIT lasts LATENCY-1 cycles.
  localparam logic [CNTW-1:0]  CNT_LOAD    = (LATENCY > 1) ? CNTW'(LATENCY - 2) : '0;
  localparam logic [ADDRW-1:0] DEPTH_LIMIT = ADDRW'(DEPTH_WORDS);

  dmem_req_t        req;
  dmem_rsp_t        rsp_q, rsp_d;
  dmem_state_e      state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]  pend_data_q;
  logic             pend_err_q;

  logic             ready;
  logic             accept;
  logic [ADDRW-1:0] offset;
  logic [ADDRW-1:0] word_off;
  logic             in_range;
  logic             req_err;
  logic [IDXW-1:0]  idx;
  logic [MASKW-1:0] byte_en;
  logic [XLEN-1:0]  bank_rdata;
  logic [XLEN-1:0]  load_data;

  assign req = '{valid: dmem.valid, addr: dmem.addr, mask: dmem.mask,
                 wdata: dmem.wdata, we: dmem.we};

  // Only WAIT blocks new requests; RESP accepts so LATENCY==1 streams.
  assign ready  = (state_q != DMEM_WAIT);
  assign accept = req.valid && ready;

  // Subtraction wraps for addresses below BASE_ADDR, hence the explicit
  // lower-bound compare.
  assign offset   = req.addr - BASE_ADDR;
  assign word_off = offset >> 2;
  assign in_range = (req.addr >= BASE_ADDR) && (word_off < DEPTH_LIMIT);
  assign idx      = word_off[IDXW-1:0];

`ifdef DMEM_RESP_ERR_EN
  assign req_err = !in_range || !mask_legal(req.mask);
`else
  assign req_err = 1'b0;
`endif

  assign byte_en   = (accept && req.we && in_range && !req_err) ? req.mask : '0;
  assign load_data = (!req.we && in_range) ? bank_rdata : '0;

  dmem_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDXW        (IDXW)
  ) u_bank (
    .clk     (clk_i),
    .byte_en (byte_en),
    .idx     (idx),
    .wdata   (req.wdata),
    .rdata   (bank_rdata)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DMEM_IDLE, DMEM_RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = DMEM_RESP;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else if (state_q == DMEM_RESP) begin
          state_d = DMEM_IDLE;
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DMEM_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  // The response register changes only on entry to RESP, so rdata/err hold
  // their last value otherwise. With LATENCY==1 the accepting cycle feeds it
  // directly; longer latencies replay the value captured at accept.
  always_comb begin
    rsp_d        = rsp_q;
    rsp_d.rvalid = (state_d == DMEM_RESP);
    if (state_d == DMEM_RESP) begin
      rsp_d.rdata = accept ? load_data : pend_data_q;
      rsp_d.err   = accept ? req_err   : pend_err_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= '0;
      rsp_q       <= '0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      if (accept) begin
        pend_data_q <= load_data;
        pend_err_q  <= req_err;
      end
    end
  end

  assign dmem.ready  = ready;
  assign dmem.rvalid = rsp_q.rvalid;
  assign dmem.rdata  = rsp_q.rdata;
  assign dmem.err    = rsp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders share one request stream: LATENCY 1 and 3 at base 0, and
// LATENCY 4 at base 0x20, all with 16 words. A behavioural model tracks each
// one's memory and pending response; a negedge process compares every output
// each cycle. Directed sequences pin literal values on top of the random run.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int          NDUT = 3;
  localparam int          LAT  [NDUT] = '{1, 3, 4};
  localparam logic [31:0] BASE [NDUT] = '{32'h0, 32'h0, 32'h20};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid, we;
  logic [31:0] addr, wdata;
  logic [3:0]  mask;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  dmem_responder_if if_a ();
  dmem_responder_if if_b ();
  dmem_responder_if if_c ();

  assign if_a.valid = valid; assign if_a.addr = addr; assign if_a.mask = mask;
  assign if_a.wdata = wdata; assign if_a.we = we;
  assign if_b.valid = valid; assign if_b.addr = addr; assign if_b.mask = mask;
  assign if_b.wdata = wdata; assign if_b.we = we;
  assign if_c.valid = valid; assign if_c.addr = addr; assign if_c.mask = mask;
  assign if_c.wdata = wdata; assign if_c.we = we;

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h0))
    u_l1 (.clk_i(clk), .rst_ni(rst_n), .dmem(if_a));
  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(3), .BASE_ADDR(32'h0))
    u_l3 (.clk_i(clk), .rst_ni(rst_n), .dmem(if_b));
  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(4), .BASE_ADDR(32'h20))
    u_l4 (.clk_i(clk), .rst_ni(rst_n), .dmem(if_c));

  logic        rdy_d [NDUT];
  logic        rv_d  [NDUT];
  logic        er_d  [NDUT];
  logic [31:0] rd_d  [NDUT];
  assign rdy_d[0] = if_a.ready;  assign rv_d[0] = if_a.rvalid;
  assign rd_d[0]  = if_a.rdata;  assign er_d[0] = if_a.err;
  assign rdy_d[1] = if_b.ready;  assign rv_d[1] = if_b.rvalid;
  assign rd_d[1]  = if_b.rdata;  assign er_d[1] = if_b.err;
  assign rdy_d[2] = if_c.ready;  assign rv_d[2] = if_c.rvalid;
  assign rd_d[2]  = if_c.rdata;  assign er_d[2] = if_c.err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model --
  // pend_m: a response is owed; due_m: edges still to pass before it shows.
  bit          pend_m  [NDUT] = '{default: 1'b0};
  int          due_m   [NDUT] = '{default: 0};
  logic [31:0] pdata_m [NDUT] = '{default: 32'h0};
  bit          perr_m  [NDUT] = '{default: 1'b0};
  bit          rv_m    [NDUT] = '{default: 1'b0};
  logic [31:0] rd_m    [NDUT] = '{default: 32'h0};
  bit          er_m    [NDUT] = '{default: 1'b0};
  logic [31:0] mem_m   [NDUT][16];

  function automatic bit ready_m(input int k);
    return !pend_m[k] || (due_m[k] == 0);
  endfunction

  task automatic model_edge(input int k);
    bit          acc, inr, err;
    logic [31:0] off, data;
    int          w;
    acc = valid && ready_m(k);
    if (pend_m[k]) begin
      if (due_m[k] == 0) pend_m[k] = 1'b0;
      else               due_m[k]--;
    end
    if (acc) begin
      off  = addr - BASE[k];
      inr  = (addr >= BASE[k]) && ((off / 4) < 16);
      w    = int'(off[5:2]);
      err  = 1'b0;
`ifdef DMEM_RESP_ERR_EN
      err  = !inr || !(mask inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0011, 4'b1100, 4'b1111});
`endif
      data = 32'h0;
      if (inr && !we) data = mem_m[k][w];
      if (inr && we && !err)
        for (int b = 0; b < 4; b++)
          if (mask[b]) mem_m[k][w][8*b +: 8] = wdata[8*b +: 8];
      pend_m[k]  = 1'b1;
      due_m[k]   = LAT[k] - 1;
      pdata_m[k] = data;
      perr_m[k]  = err;
    end
    rv_m[k] = pend_m[k] && (due_m[k] == 0);
    if (rv_m[k]) begin
      rd_m[k] = pdata_m[k];
      er_m[k] = perr_m[k];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < NDUT; k++) begin
        if (!rst_n) begin
          pend_m[k] = 1'b0; due_m[k] = 0; rv_m[k] = 1'b0;
          rd_m[k]   = 32'h0; er_m[k] = 1'b0;
        end else begin
          model_edge(k);
        end
      end
    end
  end

  // -------------------------------------------------------------- compare --
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        for (int k = 0; k < NDUT; k++) begin
          check($sformatf("dut%0d_ready", k), 32'(rdy_d[k]), 32'(ready_m(k)));
          check($sformatf("dut%0d_rvalid", k), 32'(rv_d[k]), 32'(rv_m[k]));
          check($sformatf("dut%0d_rdata", k), rd_d[k], rd_m[k]);
          if (rv_m[k]) check($sformatf("dut%0d_err", k), 32'(er_d[k]), 32'(er_m[k]));
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus --
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] d, input logic w);
    valid = v; addr = a; mask = m; wdata = d; we = w;
  endtask

  task automatic idle(input int n);
    req(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    repeat (n) cyc();
  endtask

  function automatic logic [31:0] pre_word(input int i);
    return 32'hC000_5A00 | (32'(i) << 16) | 32'(i);
  endfunction

  initial begin
    req(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    repeat (3) cyc();

    // Reset state of all three instances.
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst%0d_ready", k), 32'(rdy_d[k]), 32'd1);
      check($sformatf("rst%0d_rvalid", k), 32'(rv_d[k]), 32'd0);
      check($sformatf("rst%0d_rdata", k), rd_d[k], 32'h0);
      check($sformatf("rst%0d_err", k), 32'(er_d[k]), 32'd0);
    end
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    cyc();

    // Preload byte addresses 0x00..0x5C; each store is held long enough for
    // the slowest instance to take it.
    for (int i = 0; i < 24; i++) begin
      req(1'b1, 32'(i * 4), 4'hF, pre_word(i), 1'b1);
      repeat (5) cyc();
    end
    idle(6);

    // Store then load, LATENCY 1.
    req(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1); cyc();
    check("sl_store_rvalid", 32'(if_a.rvalid), 32'd1);
    check("sl_store_rdata", if_a.rdata, 32'h0);
    req(1'b1, 32'h10, 4'h0, 32'h0, 1'b0); cyc();
    check("sl_load_rvalid", 32'(if_a.rvalid), 32'd1);
    check("sl_load_rdata", if_a.rdata, 32'hDEAD_BEEF);
    idle(1);
    check("sl_idle_rvalid", 32'(if_a.rvalid), 32'd0);
    check("sl_hold_rdata", if_a.rdata, 32'hDEAD_BEEF);
    idle(5);

    // Single-byte store into lane 2.
    req(1'b1, 32'h10, 4'b0100, 32'h00AA_0000, 1'b1); cyc();
    idle(2);
    req(1'b1, 32'h10, 4'h0, 32'h0, 1'b0); cyc();
    check("byte_load_rdata", if_a.rdata, 32'hDEAA_BEEF);
    idle(6);

    // LATENCY 3 timing.
    req(1'b1, 32'h8, 4'h0, 32'h0, 1'b0); cyc();
    idle(0);
    check("l3_t1_ready", 32'(if_b.ready), 32'd0);
    check("l3_t1_rvalid", 32'(if_b.rvalid), 32'd0);
    cyc();
    check("l3_t2_ready", 32'(if_b.ready), 32'd0);
    check("l3_t2_rvalid", 32'(if_b.rvalid), 32'd0);
    cyc();
    check("l3_t3_rvalid", 32'(if_b.rvalid), 32'd1);
    check("l3_t3_ready", 32'(if_b.ready), 32'd1);
    check("l3_t3_rdata", if_b.rdata, 32'hC002_5A02);
    cyc();
    check("l3_t4_rvalid", 32'(if_b.rvalid), 32'd0);
    idle(5);

    // Back-to-back loads, LATENCY 1.
    begin
      logic [31:0] b2b_exp [4];
      b2b_exp = '{32'hC000_5A00, 32'hC001_5A01, 32'hC002_5A02, 32'hC003_5A03};
      for (int i = 0; i < 4; i++) begin
        req(1'b1, 32'(i * 4), 4'h0, 32'h0, 1'b0); cyc();
        check($sformatf("b2b%0d_rvalid", i), 32'(if_a.rvalid), 32'd1);
        check($sformatf("b2b%0d_ready", i), 32'(if_a.ready), 32'd1);
        check($sformatf("b2b%0d_rdata", i), if_a.rdata, b2b_exp[i]);
      end
    end
    idle(6);

    // Out-of-range store and load on the base-0 instance (word 16 of 16).
    req(1'b1, 32'h40, 4'hF, 32'h1234_5678, 1'b1); cyc();
    idle(1);
    req(1'b1, 32'h40, 4'h0, 32'h0, 1'b0); cyc();
    check("oor_rvalid", 32'(if_a.rvalid), 32'd1);
    check("oor_rdata", if_a.rdata, 32'h0);
`ifdef DMEM_RESP_ERR_EN
    check("oor_err", 32'(if_a.err), 32'd1);
`else
    check("oor_err", 32'(if_a.err), 32'd0);
`endif
    req(1'b1, 32'h0, 4'h0, 32'h0, 1'b0); cyc();
    check("oor_no_alias", if_a.rdata, 32'hC000_5A00);
    idle(6);

    // Reset in the middle of a LATENCY 4 load.
    req(1'b1, 32'h20, 4'h0, 32'h0, 1'b0); cyc();
    idle(1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    check("rmid_ready", 32'(if_c.ready), 32'd1);
    check("rmid_l1_rdata", if_a.rdata, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("rmid_rvalid%0d", i), 32'(if_c.rvalid), 32'd0);
    end

    // Random traffic across all three instances.
    for (int n = 0; n < 3000; n++) begin
      req($urandom_range(0, 3) != 0, 32'($urandom_range(0, 31)) << 2,
          ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15)),
          $urandom, $urandom_range(0, 1) != 0);
      cyc();
    end
    idle(8);

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
